bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter: accepts four packed BCD digits and returns their 16-bit binary value. It uses reverse double-dabble: shift right, then subtract 3 from any nibble ≥ 8. It is the inverse companion of the seven-segment BCD encoder path. It feeds keypad/switch-entered decimal values back into AXI register space as binary.

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_nibble_corr.sv | 20 ++
 rtl/bcd_to_bin.sv | 164 ++++++++++++++++
 tb/tb_bcd_to_bin.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Optional invalid-digit check is enabled with BCD_TO_BIN_DIGIT_CHECK_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS  = 4;
  localparam int BIN_W       = 16;
  localparam int SHIFT_COUNT = 16;
  localparam int CNT_W       = 5;

  localparam logic [3:0] BCD_CORR   = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd8;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // True when every nibble of the packed BCD word is a legal decimal digit.
  function automatic logic bcd_digits_valid(input logic [BIN_W-1:0] bcd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > BCD_MAX) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_nibble_corr.sv
// Combinational reverse double-dabble correction for one BCD nibble:
// subtracts 3 when the shifted nibble is 8 or more.
module bcd_nibble_corr
  import bcd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] corr
);

  // Nibble correction after a right shift.
  always_comb begin
    corr = nib;
    if (nib >= BCD_THRESH) begin
      corr = nib - BCD_CORR;
    end else begin
      corr = nib;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (four digits, 16 shifts per conversion).
// Define BCD_TO_BIN_DIGIT_CHECK_EN to reject digits above 9 with err.
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        busy,
  output logic        done,
  output logic [15:0] bin,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_COUNT - 1);

  state_t             state_r;
  state_t             state_s;
  logic [BIN_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   binq_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BIN_W-1:0]   digits_s;
  logic [BIN_W-1:0]   bcd_shift_s;
  logic [BIN_W-1:0]   bcd_corr_s;
  logic [BIN_W-1:0]   bin_shift_s;
  logic               last_s;
  logic               busy_r;
  logic               done_r;
  logic [BIN_W-1:0]   bin_r;

  assign digits_s    = {thousands, hundreds, tens, ones};
  // One step of the 32-bit {bcd, bin} right shift; the BCD LSB enters the binary MSB.
  assign bcd_shift_s = {1'b0, bcd_r[BIN_W-1:1]};
  assign bin_shift_s = {bcd_r[0], binq_r[BIN_W-1:1]};
  assign last_s      = (cnt_r == CNT_LAST);

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_corr
    bcd_nibble_corr u_corr (
      .nib  (bcd_shift_s[4*i +: 4]),
      .corr (bcd_corr_s[4*i +: 4])
    );
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  logic digits_ok_s;
  logic err_r;
  assign digits_ok_s = bcd_digits_valid(digits_s);
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
          if (digits_ok_s) begin
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_DONE;
          end
`else
          state_s = ST_SHIFT;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift datapath: load on accept, shift and correct while converting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_r  <= 16'h0000;
      binq_r <= 16'h0000;
      cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bcd_r  <= digits_s;
            binq_r <= 16'h0000;
            cnt_r  <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_r  <= bcd_corr_s;
          binq_r <= bin_shift_s;
          cnt_r  <= cnt_r + 5'd1;
        end
        default: begin
          bcd_r  <= bcd_r;
          binq_r <= binq_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Output registers follow the next state so busy/done line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bin_r  <= 16'h0000;
    end else begin
      busy_r <= (state_s == ST_SHIFT);
      done_r <= (state_s == ST_DONE);
      if ((state_r == ST_SHIFT) && last_s) begin
        bin_r <= bin_shift_s;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
      end else if ((state_r == ST_IDLE) && start && !digits_ok_s) begin
        bin_r <= 16'h0000;
`endif
      end else begin
        bin_r <= bin_r;
      end
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  // Error flag is decided at the accepting edge and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      err_r <= !digits_ok_s;
    end else begin
      err_r <= err_r;
    end
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign bin  = bin_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin: expected values hand-computed.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done, err;
  logic [15:0] bin;

  int n_cmp = 0;
  int n_err = 0;

  bcd_to_bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .bin       (bin),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done; lat counts negedges, bcnt counts busy samples.
  task automatic wait_done(output int lat, output int bcnt, output int both);
    lat = 0; bcnt = 0; both = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (busy && done) both++;
    end while (!done && lat < 60);
  endtask

  task automatic set_digits(input logic [15:0] d);
    {thousands, hundreds, tens, ones} = d;
  endtask

  // Full conversion with a one-cycle start pulse and timing checks.
  task automatic run_conv(input string tag, input logic [15:0] d, input logic [15:0] exp);
    int lat, bcnt, both;
    @(negedge clk);
    set_digits(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy0"}, busy, 1'b1);
    wait_done(lat, bcnt, both);
    check_eq({tag, "_lat"}, lat, 16);
    check_eq({tag, "_busycnt"}, bcnt, 15);
    check_eq({tag, "_overlap"}, both, 0);
    check_eq({tag, "_bin"}, bin, exp);
    check_eq({tag, "_err"}, err, 1'b0);
    @(negedge clk);
    check_eq({tag, "_donelow"}, done, 1'b0);
    check_eq({tag, "_hold"}, bin, exp);
  endtask

  initial begin
    int lat, bcnt, both, ndone;
    rst_n = 1'b0;
    start = 1'b0;
    set_digits(16'h0000);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_bin", bin, 16'h0000);
    check_eq("rst_err", err, 1'b0);
    rst_n = 1'b1;

    run_conv("c9999", 16'h9999, 16'h270F);
    run_conv("c1234", 16'h1234, 16'h04D2);
    run_conv("c0000", 16'h0000, 16'h0000);
    run_conv("c0001", 16'h0001, 16'h0001);
    run_conv("c4095", 16'h4095, 16'h0FFF);
    run_conv("c8888", 16'h8888, 16'h22B8);

    // Held start; digits change right after acceptance.
    @(negedge clk);
    set_digits(16'h5000);
    start = 1'b1;
    @(negedge clk);
    set_digits(16'h0042);
    wait_done(lat, bcnt, both);
    check_eq("held1_lat", lat, 16);
    check_eq("held1_bin", bin, 16'h1388);
    wait_done(lat, bcnt, both);
    start = 1'b0;
    check_eq("held2_gap", lat, 18);
    check_eq("held2_bin", bin, 16'h002A);
    check_eq("held2_overlap", both, 0);

    // Start pulses during SHIFT and DONE are ignored.
    @(negedge clk);
    set_digits(16'h1234);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    set_digits(16'h9999);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt, both);
    check_eq("ign_bin", bin, 16'h04D2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("ign_extra_done", ndone, 0);
    check_eq("ign_idle_busy", busy, 1'b0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    set_digits(16'h9999);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_bin", bin, 16'h0000);
    check_eq("abort_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check_eq("abort_quiet", ndone, 0);
    run_conv("c0800", 16'h0800, 16'h0320);

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    @(negedge clk);
    set_digits(16'h1A00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("inv_done", done, 1'b1);
    check_eq("inv_busy", busy, 1'b0);
    check_eq("inv_err", err, 1'b1);
    check_eq("inv_bin", bin, 16'h0000);
    @(negedge clk);
    check_eq("inv_donelow", done, 1'b0);
`endif
    run_conv("c0007", 16'h0007, 16'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
